// File: rtl/rr_arbiter_wslice.sv
// Round-robin arbiter, N requesters, each holding the grant for up to its own quantum; 1-cycle req->gnt, gapless handoff.
// No backpressure: gnt is a per-cycle permission, never waits on an acknowledgement.
module rr_arbiter_wslice #(
   parameter  int N  = 4,
   parameter  int CW = 4,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*CW-1:0] quantum,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [IW-1:0]   gnt_id,
   output logic            gnt_last
);

   logic [IW-1:0] owner, owner_nxt;
   logic [IW-1:0] last_owner, last_owner_nxt;
   logic [CW-1:0] count, count_nxt;
   logic [CW-1:0] q_lat, q_lat_nxt, q_win;
   logic          valid_nxt, last_nxt, hold, found;
   logic [IW-1:0] base, win;
   logic [IW:0]   cand;
   logic [N-1:0]  gnt_nxt;

   assign gnt_id = owner;

   always_comb begin
      base  = gnt_valid ? owner : last_owner;
      found = 1'b0;
      win   = owner;
      cand  = '0;
      // Offset N lands back on base, so the current owner only wins when nobody else asks.
      for (int k = 1; k <= N; k++) begin
         cand = {1'b0, base} + (IW+1)'(k);
         if (cand >= (IW+1)'(N))
            cand = cand - (IW+1)'(N);
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
      q_win = quantum[int'(win)*CW +: CW];
      if (q_win == '0)
         q_win = CW'(1);
   end

   always_comb begin
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      count_nxt      = '0;
      q_lat_nxt      = q_lat;
      valid_nxt      = 1'b0;
      gnt_nxt        = '0;
      hold           = gnt_valid && req[owner] && (count < q_lat - CW'(1));
      if (hold) begin
         count_nxt = count + CW'(1);
         valid_nxt = 1'b1;
      end else if (found) begin
         owner_nxt      = win;
         last_owner_nxt = win;
         q_lat_nxt      = q_win;
         valid_nxt      = 1'b1;
      end
      if (valid_nxt)
         gnt_nxt[owner_nxt] = 1'b1;
      last_nxt = valid_nxt && (count_nxt == q_lat_nxt - CW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= '0;
         last_owner <= IW'(N-1);
         count      <= '0;
         q_lat      <= CW'(1);
         gnt_valid  <= 1'b0;
         gnt        <= '0;
         gnt_last   <= 1'b0;
      end else begin
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         count      <= count_nxt;
         q_lat      <= q_lat_nxt;
         gnt_valid  <= valid_nxt;
         gnt        <= gnt_nxt;
         gnt_last   <= last_nxt;
      end
   end

endmodule

// File: doc/rr_arbiter_wslice.md
# rr_arbiter_wslice

Parametrised round-robin arbiter with a per-requester programmable time slice (quantum), generalising the team's fixed 4-way / fixed 3-cycle variable-time-slice arbiter. It serves N requesters. A granted requester keeps the grant for up to its own quantum of consecutive cycles, or until it drops its request. Handoff to the next requester has no idle cycle, and the grant is reported as one-hot, as an index, and with an end-of-slice flag. It sits in front of a shared resource (bus port, memory bank) that accepts one owner per cycle.

## Interface
- N, default 4: number of requesters; N ≥ 2.
- CW, default 4: quantum field width; maximum slice is 2^CW−1 cycles.
- IW, default $clog2(N): index width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request per channel; bit i belongs to channel i.
- quantum  in  N*CW  slice length per channel; channel i uses bits [i*CW +: CW]; a value of 0 is treated as 1.
- gnt  out  N  registered one-hot grant, or all zeros.
- gnt_valid  out  1  registered; equals |gnt.
- gnt_id  out  IW  registered index of the granted channel; holds its last value when gnt_valid=0.
- gnt_last  out  1  registered; high in the final cycle of the current slice (count == Q−1).

## Operation
- State: owner (IW bits), last_owner (IW bits), count (CW bits), q_lat (CW bits, the latched effective quantum), gnt_valid.
- Reset (rst=1 at an edge): gnt=0, gnt_valid=0, gnt_id=0, gnt_last=0, count=0, q_lat=1. last_owner=N−1, so the first search starts at channel 0.
- Effective quantum: Q(i) = (quantum[i]==0) ? 1 : quantum[i].
  - Q is latched into q_lat only when a grant is issued.
  - Changes to quantum in mid-slice have no effect until the next grant.
- Hold condition, evaluated each edge: gnt_valid && req[owner] && (count < q_lat−1).
  - If it holds, the owner is kept and count increments.
- Otherwise, rearbitrate:
  - Search offsets k = 1..N from base = gnt_valid ? owner : last_owner. Candidate = (base+k) mod N. The first candidate with req set wins.
  - Offset N is the base itself. The current owner is therefore re-granted (fresh slice, count=0) only if no other channel requests.
  - On a winner: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, count=0, q_lat=Q(winner), last_owner=winner.
  - If there is no winner: gnt=0, gnt_valid=0, count=0. gnt_id and last_owner keep their values.
- Early release: if the owner deasserts req in any grant cycle, the next edge rearbitrates. There is no idle cycle if another channel requests.
- The modulo-N wrap must be correct for non-power-of-two N. Use an explicit compare-and-subtract, not bit truncation.
- gnt_last is registered: its next value is 1 when the next state has gnt_valid=1 and next count == q_lat_next−1.
  - With Q=1, gnt_last is high in every grant cycle.
- Granting does not depend on any acknowledgement. Requesters must treat gnt as permission for that cycle only.

## Timing
- Latency from request to grant: 1 cycle. req sampled high at edge t gives gnt at t+1, provided the arbiter is idle or rearbitrating at t.
- Slice length: exactly q_lat consecutive gnt cycles if req is held; fewer if req drops.
- Fairness bound: with all channels requesting, a channel waits at most the sum of Q(j) over j≠i cycles between its slices.
- Release latency: req drop seen at edge t means gnt moves (or clears) at t+1. The owner still shows gnt in the cycle it drops req.
- Reset mid-slice: all outputs are 0 the cycle after the rst edge. After rst falls, arbitration restarts from channel 0.
- Outputs carry no combinational path from inputs.

## Test plan
- N=4, CW=4. rst held 3 cycles, then released with req=0 → gnt=0000, gnt_valid=0, gnt_id=0, gnt_last=0 throughout.
- req=1111, quantum all 3 → gnt 0001×3, 0010×3, 0100×3, 1000×3, then 0001… with no gaps; gnt_last high on the 3rd cycle of each slice.
- req=1111, quantum ch0..ch3 = 1, 2, 4, 0 → slices of 1, 2, 4, 1 cycles in order 0→1→2→3→0; gnt_last on each final cycle.
- ch1 granted with Q=5, ch2 requesting; ch1 drops req after 2 grant cycles → next cycle gnt=0100, no 0000 cycle; ch1's slice totals 2 or 3 cycles depending on drop timing, with gnt_last never seen for ch1.
- Only ch2 requests, Q=2 → gnt=0100 continuously; gnt_last toggles 0,1,0,1. Then ch0 raises req → ch0 is granted directly after the next gnt_last cycle.
- Assert rst during the 2nd cycle of ch3's slice with req=1111 → outputs clear next cycle; after release the first grant is 0001.
